// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared types and constants for the triggered waveform capture block.
//   state_t       : capture state machine encoding
//   CH_W / IDX_W  : channel / index widths for the default configuration
//   TRIG_*        : trigger polarity encodings for trig_rising
// -----------------------------------------------------------------------------
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 1024;
    localparam int CH_W         = $clog2(DEF_CHANNELS);
    localparam int IDX_W        = $clog2(DEF_DEPTH);

    localparam logic TRIG_FALLING = 1'b0;
    localparam logic TRIG_RISING  = 1'b1;

endpackage

// File: rtl/scope_capture_ram.sv
// -----------------------------------------------------------------------------
// scope_capture_ram
// Per-channel simple dual-port sample memory (CHANNELS x DEPTH x SAMPLE_W).
// One synchronous write port, one read port with a registered output.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (read register only)
//   wr_en/wr_ch/wr_addr : write strobe, channel and set index
//   wr_data             : sample to store
//   rd_ch/rd_addr       : read channel and set index
//   rd_data             : registered read data, one cycle after the address
// -----------------------------------------------------------------------------
module scope_capture_ram
    import scope_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [SAMPLE_W-1:0]         wr_data,
    input  logic [$clog2(CHANNELS)-1:0] rd_ch,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [SAMPLE_W-1:0]         rd_data
);

    localparam int C_W   = $clog2(CHANNELS);
    localparam int I_W   = $clog2(DEPTH);
    localparam int WORDS = 1 << (C_W + I_W);

    // Channel is the upper address field so each channel owns a contiguous bank.
    logic [SAMPLE_W-1:0] mem_r [WORDS];

    // Write port: memory array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[{wr_ch, wr_addr}] <= wr_data;
        end
    end

    // Read port: registered output, cleared by reset so the display sees zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= {SAMPLE_W{1'b0}};
        end else begin
            rd_data <= mem_r[{rd_ch, rd_addr}];
        end
    end

endmodule

// File: rtl/scope_capture.sv
// -----------------------------------------------------------------------------
// scope_capture
// Multi-channel triggered waveform capture buffer. Round-robin ADC samples are
// written into a per-channel circular buffer; a level-crossing trigger on a
// selected channel freezes a window of DEPTH sets with PRETRIG sets of history.
// Optional build macro SCOPE_CAPTURE_AUTO_TRIG_EN forces a trigger after
// AUTO_TIMEOUT sets in ARMED; without it ARMED waits indefinitely.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   sample_valid/_ch/_data      : incoming ADC sample strobe, channel, code
//   arm                         : pulse, start (or restart) a capture
//   trig_ch/trig_level/trig_rising : live trigger configuration
//   rd_ch/rd_idx                : readback address, idx 0 = oldest set
//   rd_data                     : registered readback, 1-cycle latency
//   busy / done / seq_err       : capture running / window frozen / order error
// -----------------------------------------------------------------------------
module scope_capture
    import scope_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_W     = 16,
    parameter int DEPTH        = 1024,
    parameter int PRETRIG      = 256,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_valid,
    input  logic [$clog2(CHANNELS)-1:0] sample_ch,
    input  logic [SAMPLE_W-1:0]         sample_data,
    input  logic                        arm,
    input  logic [$clog2(CHANNELS)-1:0] trig_ch,
    input  logic [SAMPLE_W-1:0]         trig_level,
    input  logic                        trig_rising,
    input  logic [$clog2(CHANNELS)-1:0] rd_ch,
    input  logic [$clog2(DEPTH)-1:0]    rd_idx,
    output logic [SAMPLE_W-1:0]         rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        seq_err
);

    localparam int C_W     = $clog2(CHANNELS);
    localparam int I_W     = $clog2(DEPTH);
    localparam int CNT_MAX = (DEPTH > AUTO_TIMEOUT) ? DEPTH : AUTO_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_SETS  = CNT_W'(PRETRIG);
    localparam logic [CNT_W-1:0] POST_SETS = CNT_W'(DEPTH - PRETRIG);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [C_W-1:0]   LAST_CH   = C_W'(CHANNELS - 1);
    localparam logic [I_W-1:0]   PRE_OFS   = I_W'(PRETRIG);
    localparam logic             PRE_ZERO  = (PRETRIG == 0);
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
    localparam logic [CNT_W-1:0] AUTO_SETS = CNT_W'(AUTO_TIMEOUT);
`endif

    state_t              state_r;
    logic [I_W-1:0]      wr_ptr_r;
    logic [C_W-1:0]      exp_ch_r;
    logic [CNT_W-1:0]    set_cnt_r;
    logic [SAMPLE_W-1:0] prev_r;
    logic                prev_valid_r;
    logic [I_W-1:0]      trig_ptr_r;
    logic                busy_r;
    logic                done_r;
    logic                seq_err_r;

    logic                write_state_s;
    logic                accept_s;
    logic                mismatch_s;
    logic                set_done_s;
    logic                trig_sample_s;
    logic                hit_s;
    logic [CNT_W-1:0]    set_cnt_inc_s;
    logic [CNT_W-1:0]    post_cnt_init_s;
    logic                post_fin_s;
    logic [C_W-1:0]      exp_ch_next_s;
    logic [I_W-1:0]      rd_addr_s;

    // Sample acceptance, trigger detection and readback address decode.
    always_comb begin
        write_state_s   = 1'b0;
        accept_s        = 1'b0;
        mismatch_s      = 1'b0;
        set_done_s      = 1'b0;
        trig_sample_s   = 1'b0;
        hit_s           = 1'b0;
        set_cnt_inc_s   = set_cnt_r + CNT_ONE;
        post_cnt_init_s = {CNT_W{1'b0}};
        post_fin_s      = 1'b0;
        exp_ch_next_s   = exp_ch_r;
        rd_addr_s       = trig_ptr_r - PRE_OFS + rd_idx;

        write_state_s = (state_r == ST_FILL) || (state_r == ST_ARMED) ||
                        (state_r == ST_POST);
        // arm takes priority: a sample coinciding with arm is not stored.
        accept_s      = sample_valid && write_state_s && !arm &&
                        (sample_ch == exp_ch_r);
        mismatch_s    = sample_valid && write_state_s && !arm &&
                        (sample_ch != exp_ch_r);
        set_done_s    = accept_s && (exp_ch_r == LAST_CH);
        trig_sample_s = accept_s && (sample_ch == trig_ch);

        if (exp_ch_r == LAST_CH) begin
            exp_ch_next_s = {C_W{1'b0}};
        end else begin
            exp_ch_next_s = exp_ch_r + C_W'(1'b1);
        end

        if (trig_rising == TRIG_RISING) begin
            hit_s = prev_valid_r && (prev_r < trig_level) &&
                    (sample_data >= trig_level);
        end else begin
            hit_s = prev_valid_r && (prev_r > trig_level) &&
                    (sample_data <= trig_level);
        end

        // When the trigger lands on the last channel the trigger set is
        // already complete in that cycle and counts toward the post window.
        if (set_done_s) begin
            post_cnt_init_s = CNT_ONE;
            post_fin_s      = (POST_SETS == CNT_ONE);
        end else begin
            post_cnt_init_s = {CNT_W{1'b0}};
            post_fin_s      = 1'b0;
        end
    end

    // Capture state machine with pointers, trigger history and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {I_W{1'b0}};
            exp_ch_r     <= {C_W{1'b0}};
            set_cnt_r    <= {CNT_W{1'b0}};
            prev_r       <= {SAMPLE_W{1'b0}};
            prev_valid_r <= 1'b0;
            trig_ptr_r   <= {I_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            seq_err_r    <= 1'b0;
        end else if (arm) begin
            // wr_ptr deliberately keeps running across captures.
            state_r      <= ST_FILL;
            exp_ch_r     <= {C_W{1'b0}};
            set_cnt_r    <= {CNT_W{1'b0}};
            prev_valid_r <= 1'b0;
            seq_err_r    <= 1'b0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                exp_ch_r <= exp_ch_next_s;
            end
            if (set_done_s) begin
                wr_ptr_r <= wr_ptr_r + I_W'(1'b1);
            end
            if (mismatch_s) begin
                seq_err_r <= 1'b1;
            end
            // History keeps updating in FILL so ARMED starts with a valid prev.
            if (trig_sample_s && ((state_r == ST_FILL) || (state_r == ST_ARMED))) begin
                prev_r       <= sample_data;
                prev_valid_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                ST_FILL: begin
                    if (PRE_ZERO) begin
                        state_r   <= ST_ARMED;
                        set_cnt_r <= {CNT_W{1'b0}};
                    end else if (set_done_s) begin
                        if (set_cnt_inc_s == PRE_SETS) begin
                            state_r   <= ST_ARMED;
                            set_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            set_cnt_r <= set_cnt_inc_s;
                        end
                    end
                end
                ST_ARMED: begin
                    if (trig_sample_s && hit_s) begin
                        trig_ptr_r <= wr_ptr_r;
                        set_cnt_r  <= post_cnt_init_s;
                        if (post_fin_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_POST;
                        end
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
                    end else if (set_done_s) begin
                        if (set_cnt_inc_s == AUTO_SETS) begin
                            // Forced trigger: the set just completed is the trigger set.
                            trig_ptr_r <= wr_ptr_r;
                            set_cnt_r  <= CNT_ONE;
                            if (POST_SETS == CNT_ONE) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_POST;
                            end
                        end else begin
                            set_cnt_r <= set_cnt_inc_s;
                        end
`endif
                    end
                end
                ST_POST: begin
                    if (set_done_s) begin
                        if (set_cnt_inc_s == POST_SETS) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            set_cnt_r <= set_cnt_inc_s;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign seq_err = seq_err_r;

    scope_capture_ram #(
        .CHANNELS (CHANNELS),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept_s),
        .wr_ch   (exp_ch_r),
        .wr_addr (wr_ptr_r),
        .wr_data (sample_data),
        .rd_ch   (rd_ch),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_scope_capture.sv
// -----------------------------------------------------------------------------
// tb_scope_capture
// Directed self-checking bench for scope_capture with CHANNELS=4, SAMPLE_W=16,
// DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=8. Honours SCOPE_CAPTURE_AUTO_TRIG_EN.
// -----------------------------------------------------------------------------
module tb_scope_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [15:0] sample_data;
    logic        arm;
    logic [1:0]  trig_ch;
    logic [15:0] trig_level;
    logic        trig_rising;
    logic [1:0]  rd_ch;
    logic [3:0]  rd_idx;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        seq_err;

    int n_cmp = 0;
    int n_err = 0;

    // Ramp window for the rising-trigger capture: sets 3..18 of (k+1)*0x1000.
    logic [15:0] exp_ramp [16] = '{16'h4000, 16'h5000, 16'h6000, 16'h7000,
                                   16'h8000, 16'h9000, 16'hA000, 16'hB000,
                                   16'hC000, 16'hD000, 16'hE000, 16'hF000,
                                   16'h0000, 16'h1000, 16'h2000, 16'h3000};

    // Wrap capture window: sets 36..51, trigger at set 40 (value 0x8000+set).
    logic [15:0] exp_wrap [16] = '{16'h0024, 16'h0025, 16'h0026, 16'h0027,
                                   16'h8028, 16'h8029, 16'h802A, 16'h802B,
                                   16'h802C, 16'h802D, 16'h802E, 16'h802F,
                                   16'h8030, 16'h8031, 16'h8032, 16'h8033};

    scope_capture #(
        .CHANNELS     (4),
        .SAMPLE_W     (16),
        .DEPTH        (16),
        .PRETRIG      (4),
        .AUTO_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .arm          (arm),
        .trig_ch      (trig_ch),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .rd_ch        (rd_ch),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = d;
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic send_set(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        send(2'd0, d0);
        send(2'd1, d1);
        send(2'd2, d2);
        send(2'd3, d3);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = 16'h0000;
        arm          = 1'b0;
        trig_ch      = 2'd1;
        trig_level   = 16'h8000;
        trig_rising  = 1'b1;
        rd_ch        = 2'd1;
        rd_idx       = 4'd0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_seq_err", seq_err, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        // ---- Reset in the middle of POST ----
        pulse_arm();
        check("t1_busy_after_arm", busy, 32'd1);
        send(2'd2, 16'h1111);
        check("t1_seq_err_set", seq_err, 32'd1);
        for (int k = 0; k < 10; k++) begin
            send_set(16'h0000, 16'((k + 1) * 4096), 16'h0000, 16'h0000);
        end
        check("t1_busy_in_post", busy, 32'd1);
        check("t1_done_in_post", done, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_busy", busy, 32'd0);
        check("t1_async_done", done, 32'd0);
        check("t1_async_seq_err", seq_err, 32'd0);
        check("t1_async_rd_data", rd_data, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        send(2'd3, 16'h2222);
        send_set(16'h0001, 16'h9000, 16'h0003, 16'h0004);
        check("t1_idle_busy", busy, 32'd0);
        check("t1_idle_done", done, 32'd0);
        check("t1_idle_seq_err", seq_err, 32'd0);

        // ---- Rising trigger on ch1 ramp ----
        trig_ch     = 2'd1;
        trig_rising = 1'b1;
        trig_level  = 16'h8000;
        pulse_arm();
        for (int k = 0; k < 19; k++) begin
            send_set(16'(k), 16'((k + 1) * 4096), 16'h2000, 16'h3000);
            if (k == 17) begin
                check("t2_done_set17", done, 32'd0);
                check("t2_busy_set17", busy, 32'd1);
            end
        end
        check("t2_done_set18", done, 32'd1);
        check("t2_busy_set18", busy, 32'd0);
        rd_ch  = 2'd1;
        rd_idx = 4'd0;
        cyc();
        check("t2_rd_idx0", rd_data, 32'(exp_ramp[0]));
        for (int i = 1; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("t2_lag_idx%0d", i), rd_data, 32'(exp_ramp[i-1]));
            cyc();
            check($sformatf("t2_rd_idx%0d", i), rd_data, 32'(exp_ramp[i]));
        end
        rd_ch  = 2'd0;
        rd_idx = 4'd4;
        cyc();
        check("t2_ch0_trigset", rd_data, 32'h0007);

        // ---- Falling trigger on ch2 ----
        trig_ch     = 2'd2;
        trig_rising = 1'b0;
        pulse_arm();
        check("t3_busy_after_arm", busy, 32'd1);
        for (int k = 0; k < 19; k++) begin
            send_set(16'hA5A5, 16'(k), 16'hF000 - 16'(k * 4096), 16'h5A5A);
            if (k == 17) begin
                check("t3_done_set17", done, 32'd0);
            end
        end
        check("t3_done_set18", done, 32'd1);
        rd_ch  = 2'd2;
        rd_idx = 4'd4;
        cyc();
        check("t3_ch2_idx4", rd_data, 32'h8000);
        rd_idx = 4'd0;
        cyc();
        check("t3_ch2_idx0", rd_data, 32'hC000);
        rd_idx = 4'd15;
        cyc();
        check("t3_ch2_idx15", rd_data, 32'hD000);
        send_set(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        rd_idx = 4'd4;
        cyc();
        check("t3_frozen_idx4", rd_data, 32'h8000);
        check("t3_frozen_done", done, 32'd1);
        check("t3_frozen_seq_err", seq_err, 32'd0);

        // ---- Out-of-order samples plus pointer wrap ----
        trig_ch     = 2'd0;
        trig_rising = 1'b1;
        trig_level  = 16'h8000;
        pulse_arm();
        check("t6_rearm_busy", busy, 32'd1);
        check("t6_rearm_done", done, 32'd0);
        send(2'd0, 16'h0000);
        send(2'd1, 16'h0100);
        send(2'd3, 16'hDEAD);
        check("t4_seq_err", seq_err, 32'd1);
        send(2'd2, 16'h0200);
        send(2'd3, 16'h0300);
        for (int k = 1; k < 52; k++) begin
            send_set((k < 40) ? 16'(k) : 16'(32768 + k), 16'h0100, 16'h0200, 16'h0300);
            if (k == 50) begin
                check("t6_done_set50", done, 32'd0);
            end
        end
        check("t6_done_set51", done, 32'd1);
        check("t4_seq_err_sticky", seq_err, 32'd1);
        rd_ch = 2'd0;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            cyc();
            check($sformatf("t6_rd_idx%0d", i), rd_data, 32'(exp_wrap[i]));
        end

        // ---- Flat input: auto trigger or indefinite wait ----
        pulse_arm();
        check("t4_arm_clears_seq_err", seq_err, 32'd0);
        check("t5_busy_after_arm", busy, 32'd1);
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
        for (int k = 0; k < 23; k++) begin
            send_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
            if (k == 21) begin
                check("t5_auto_done_set21", done, 32'd0);
            end
        end
        check("t5_auto_done_set22", done, 32'd1);
        check("t5_auto_busy_set22", busy, 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            send_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        end
        check("t5_no_auto_done", done, 32'd0);
        check("t5_no_auto_busy", busy, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
